// File: rtl/dmux1t2_64_buf.sv
// Buffered 1-to-2 demultiplexer: one producer stream routed to slot A or B,
// each slot a one-entry valid/ready holding register with a transfer counter.
module dmux1t2_64_buf #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [CNT_W-1:0] a_cnt,
   output logic [CNT_W-1:0] b_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_t;

   slot_t            a_state, a_state_nxt;
   slot_t            b_state, b_state_nxt;
   logic [WIDTH-1:0] a_data_nxt, b_data_nxt;
   logic [CNT_W-1:0] a_cnt_nxt, b_cnt_nxt;
   logic             load_a, load_b, drain_a, drain_b;

   assign a_valid = (a_state == FULL);
   assign b_valid = (b_state == FULL);

   // A slot can take a word if it is empty or is being drained this same edge.
   assign in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready);

   assign load_a  = in_valid & in_ready & ~in_sel;
   assign load_b  = in_valid & in_ready &  in_sel;
   assign drain_a = a_valid & a_ready;
   assign drain_b = b_valid & b_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      a_state_nxt = a_state;
      b_state_nxt = b_state;
      a_data_nxt  = a_data;
      b_data_nxt  = b_data;
      a_cnt_nxt   = a_cnt;
      b_cnt_nxt   = b_cnt;

      if (drain_a) begin
         a_state_nxt = EMPTY;
         a_cnt_nxt   = a_cnt + CNT_W'(1);
      end
      // Load after drain so a same-edge drain+load leaves the slot FULL.
      if (load_a) begin
         a_state_nxt = FULL;
         a_data_nxt  = in_data;
      end

      if (drain_b) begin
         b_state_nxt = EMPTY;
         b_cnt_nxt   = b_cnt + CNT_W'(1);
      end
      if (load_b) begin
         b_state_nxt = FULL;
         b_data_nxt  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         a_state <= EMPTY;
         b_state <= EMPTY;
         // NOTE: the data registers are reset as well because their zero value is visible on a_data/b_data after reset.
         a_data  <= '0;
         b_data  <= '0;
         a_cnt   <= '0;
         b_cnt   <= '0;
      end else begin
         a_state <= a_state_nxt;
         b_state <= b_state_nxt;
         a_data  <= a_data_nxt;
         b_data  <= b_data_nxt;
         a_cnt   <= a_cnt_nxt;
         b_cnt   <= b_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_dmux1t2_64_buf.sv
// Directed self-checking bench for dmux1t2_64_buf; counters built 4 bits wide
// so the wrap case is reachable in a few transfers.
module tb_dmux1t2_64_buf;

   localparam int WIDTH = 64;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;
   logic [CNT_W-1:0] a_cnt;
   logic [CNT_W-1:0] b_cnt;

   int vectors = 0;
   int errors  = 0;

   localparam logic [WIDTH-1:0] W0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [WIDTH-1:0] W1 = 64'h1111_0000_1111_0001;
   localparam logic [WIDTH-1:0] W2 = 64'h2222_0000_2222_0002;
   localparam logic [WIDTH-1:0] W3 = 64'h3333_0000_3333_0003;
   localparam logic [WIDTH-1:0] WA = 64'hAAAA;
   localparam logic [WIDTH-1:0] WB = 64'hBBBB;

   dmux1t2_64_buf #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .a_cnt    (a_cnt),
      .b_cnt    (b_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step();
      rst      = 1'b1;
      in_valid = 1'b0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      step();
      rst      = 1'b0;
   endtask

   task automatic send(input logic sel, input logic [WIDTH-1:0] d);
      step();
      in_sel   = sel;
      in_data  = d;
      in_valid = 1'b1;
   endtask

   task automatic idle();
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sel   = 1'b0;
      in_data  = '0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;

      // Reset state
      repeat (2) step();
      #1;
      check("rst_a_valid", 64'(a_valid), 64'd0);
      check("rst_b_valid", 64'(b_valid), 64'd0);
      check("rst_a_data",  a_data, 64'd0);
      check("rst_b_data",  b_data, 64'd0);
      check("rst_a_cnt",   64'(a_cnt), 64'd0);
      check("rst_b_cnt",   64'(b_cnt), 64'd0);
      rst = 1'b0;

      // Single word to A, drained the cycle after it appears
      a_ready = 1'b1;
      send(1'b0, W0);
      #1 check("t1_in_ready", 64'(in_ready), 64'd1);
      idle();
      #1;
      check("t1_a_valid", 64'(a_valid), 64'd1);
      check("t1_a_data",  a_data, W0);
      check("t1_b_valid", 64'(b_valid), 64'd0);
      check("t1_a_cnt0",  64'(a_cnt), 64'd0);
      step();
      #1;
      check("t1_a_empty", 64'(a_valid), 64'd0);
      check("t1_a_cnt1",  64'(a_cnt), 64'd1);
      check("t1_a_keep",  a_data, W0);

      // A back-pressure while B stays open
      a_ready = 1'b0;
      send(1'b0, W1);
      #1 check("t2_rdy_w1", 64'(in_ready), 64'd1);
      send(1'b0, W2);
      #1;
      check("t2_a_valid", 64'(a_valid), 64'd1);
      check("t2_rdy_w2",  64'(in_ready), 64'd0);
      check("t2_a_w1",    a_data, W1);
      step();
      #1;
      check("t2_a_hold",  a_data, W1);
      check("t2_a_vhold", 64'(a_valid), 64'd1);
      in_sel  = 1'b1;
      in_data = W3;
      #1 check("t2_rdy_w3", 64'(in_ready), 64'd1);
      idle();
      #1;
      check("t2_b_valid", 64'(b_valid), 64'd1);
      check("t2_b_w3",    b_data, W3);
      check("t2_a_still", a_data, W1);
      check("t2_a_cnt",   64'(a_cnt), 64'd1);

      // Streaming: five back-to-back A words with constant a_ready
      do_reset();
      a_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(1'b0, 64'(i));
         #1;
         check("t3_in_ready", 64'(in_ready), 64'd1);
         if (i > 1) begin
            check("t3_a_valid", 64'(a_valid), 64'd1);
            check("t3_a_data",  a_data, 64'(i - 1));
            check("t3_a_cnt",   64'(a_cnt), 64'(i - 2));
         end
      end
      idle();
      #1;
      check("t3_a_last",  a_data, 64'd5);
      check("t3_a_cnt4",  64'(a_cnt), 64'd4);
      step();
      #1;
      check("t3_a_empty", 64'(a_valid), 64'd0);
      check("t3_a_cnt5",  64'(a_cnt), 64'd5);

      // Dual drain in the same cycle
      do_reset();
      send(1'b0, WA);
      send(1'b1, WB);
      idle();
      #1;
      check("t4_a_full", 64'(a_valid), 64'd1);
      check("t4_b_full", 64'(b_valid), 64'd1);
      check("t4_a_data", a_data, WA);
      check("t4_b_data", b_data, WB);
      a_ready = 1'b1;
      b_ready = 1'b1;
      step();
      #1;
      check("t4_a_empty", 64'(a_valid), 64'd0);
      check("t4_b_empty", 64'(b_valid), 64'd0);
      check("t4_a_cnt",   64'(a_cnt), 64'd1);
      check("t4_b_cnt",   64'(b_cnt), 64'd1);

      // Mid-operation reset with both slots full and counters at 3/7
      do_reset();
      a_ready = 1'b1;
      b_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(1'b0, 64'(i));
      for (int i = 0; i < 7; i++) send(1'b1, 64'(i));
      idle();
      step();
      a_ready = 1'b0;
      b_ready = 1'b0;
      send(1'b0, WA);
      send(1'b1, WB);
      idle();
      #1;
      check("t5_a_cnt3",  64'(a_cnt), 64'd3);
      check("t5_b_cnt7",  64'(b_cnt), 64'd7);
      check("t5_a_full",  64'(a_valid), 64'd1);
      check("t5_b_full",  64'(b_valid), 64'd1);
      rst      = 1'b1;
      in_sel   = 1'b0;
      in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      in_valid = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("t5_a_valid", 64'(a_valid), 64'd0);
      check("t5_b_valid", 64'(b_valid), 64'd0);
      check("t5_a_data",  a_data, 64'd0);
      check("t5_b_data",  b_data, 64'd0);
      check("t5_a_cnt",   64'(a_cnt), 64'd0);
      check("t5_b_cnt",   64'(b_cnt), 64'd0);
      step();
      #1 check("t5_lost", 64'(a_valid), 64'd0);

      // Counter wrap over 17 B transfers (4-bit counter)
      do_reset();
      b_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         send(1'b1, 64'(i));
         idle();
         step();
         #1 check("t6_b_cnt", 64'(b_cnt), 64'(i % 16));
      end
      check("t6_b_data", b_data, 64'd17);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
